adc_line_reader: RTL and testbench
==================================

Name: adc_line_reader

Overview:
- Drains one captured AD9826 line out of the sample RAM after the capture engine reports completion.
- The capture engine writes 32-bit words, each holding two 16-bit pixels, at byte addresses base+4k.
- This block is the read side of that RAM. It issues word reads and unpacks each word into two 16-bit pixels.
- Pixels leave on a valid/ready stream with a last flag, feeding the host transfer path (UART/DMA packetiser).

Parameters:
- PIX_NUM, 512, pixels per line; must be even. Words per line = PIX_NUM/2.
- BUF_DEPTH, 2, depth of the internal word buffer in 32-bit words; must be at least 2.

Ports:
- clk  in  1  single system clock, shared with the capture side and the RAM read port
- rst_n  in  1  asynchronous active-low reset
- line_done_in  in  1  one-cycle pulse from the capture engine: a line is complete in RAM
- base_addr_in  in  32  byte address of word 0; sampled on an accepted start
- ram_addr_o  out  32  RAM read byte address
- ram_rd_o  out  1  RAM read strobe; ram_data_in is valid exactly 1 cycle later
- ram_data_in  in  32  RAM read data: [31:16] is the earlier pixel, [15:0] the later pixel
- pix_data_o  out  16  pixel data
- pix_valid_o  out  1  pixel valid
- pix_ready_in  in  1  downstream ready
- pix_last_o  out  1  asserted together with the final pixel of the line
- busy_o  out  1  high from an accepted start until the DONE state
- line_sent_o  out  1  one-cycle pulse after the last pixel handshake
- overrun_o  out  1  sticky; set when line_done_in arrives while busy

Behaviour:
- Reset (async, rst_n=0) values:
  - all outputs 0, ram_addr_o=0, state=IDLE;
  - buffer emptied, in-flight read discarded, all counters cleared.
- State machine IDLE -> RUN -> DONE -> IDLE:
  - IDLE: on line_done_in=1, latch base_addr_in, clear word and pixel counters, go to RUN. busy_o rises the next cycle.
  - RUN: issue reads and stream pixels. Leave RUN on the cycle the pixel with index PIX_NUM-1 handshakes (pix_valid_o && pix_ready_in).
  - DONE: one cycle; line_sent_o=1, busy_o=0, then return to IDLE.
- Read issue rule:
  - ram_rd_o=1 in a cycle when in RUN, words_issued < PIX_NUM/2, and (buffer occupancy + reads in flight) < BUF_DEPTH.
  - ram_addr_o = base + 4*words_issued, computed modulo 2^32, so the address wraps past 0xFFFFFFFC.
  - ram_rd_o is combinationally high only for that cycle. The read data is written into the buffer on the next clk edge.
  - First ram_rd_o occurs on the cycle after the start is accepted.
- Unpack and output:
  - The head word is presented as two pixels: [31:16] first, then [15:0].
  - A half-select bit toggles on each handshake. The word is popped when its lower half handshakes.
  - pix_valid_o = buffer not empty (registered buffer, no combinational path from ram_data_in).
  - pix_data_o is held stable while pix_valid_o=1 and pix_ready_in=0.
- Latency: the first pixel is valid 3 cycles after the line_done_in cycle (accept, read, buffer write).
- Throughput: one pixel per cycle sustained with pix_ready_in held at 1. No bubble when BUF_DEPTH >= 2.
- pix_last_o is high only while the pixel with index PIX_NUM-1 is presented.
- Boundary cases:
  - line_done_in while busy_o=1 or in DONE: the start is ignored and overrun_o is set. overrun_o clears only on reset.
  - Buffer full: reads stall. The in-flight counter guarantees no buffer overflow.
  - pix_ready_in=0 for an arbitrarily long time: no data loss, no extra reads.
- No behaviour depends on pixel values.

Optional Feature:
- Macro: ADC_READER_BYTE_SWAP_EN.
- Defined: each output pixel has its bytes swapped, pix_data_o = {p[7:0], p[15:8]}. This compensates for the IDDR Q1/Q2 edge ordering on the capture side.
- Undefined: pixels are passed unchanged.
- Only pix_data_o is affected; timing and the handshake are identical in both cases.

Test Plan:
- PIX_NUM=8, base=0x100, RAM word k = {16'hA000+2k, 16'hA001+2k}, ready held at 1, pulse line_done_in:
  - reads at addresses 0x100, 0x104, 0x108, 0x10C;
  - pixels A000..A007 in order, one per cycle;
  - pix_last_o on A007, line_sent_o pulses the next cycle.
- Same line with pix_ready_in toggling 1,0,0,1 repeating: identical pixel sequence, data stable while stalled, never more than 2 reads outstanding.
- base=0xFFFFFFF8, PIX_NUM=8: addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Second line_done_in 5 cycles after the first: overrun_o=1, the first line completes normally with exactly PIX_NUM pixels, no second line is sent.
- rst_n asserted mid-line after 3 pixels, then released and a new start applied:
  - all outputs 0 immediately during reset;
  - the new line streams all pixels from index 0.
- With ADC_READER_BYTE_SWAP_EN defined and word 0x12345678: output 0x3412 then 0x7856.

Source files
------------

// File: rtl/adc_line_reader.sv
// adc_line_reader: read side of the AD9826 line RAM.
// After the capture engine signals line completion, reads PIX_NUM/2 words
// starting at the latched base address, buffers them, and streams each word
// out as two 16-bit pixels (upper half first) on a valid/ready interface.
// Optional macro ADC_READER_BYTE_SWAP_EN swaps the bytes of every output pixel.
module adc_line_reader #(
  parameter int PIX_NUM   = 512,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_done_in,
  input  logic [31:0] base_addr_in,
  output logic [31:0] ram_addr_o,
  output logic        ram_rd_o,
  input  logic [31:0] ram_data_in,
  output logic [15:0] pix_data_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_in,
  output logic        pix_last_o,
  output logic        busy_o,
  output logic        line_sent_o,
  output logic        overrun_o
);

  localparam int WORDS = PIX_NUM / 2;
  localparam int WCW   = $clog2(WORDS + 1);
  localparam int PCW   = (PIX_NUM > 2) ? $clog2(PIX_NUM) : 1;
  localparam int PW    = $clog2(BUF_DEPTH);
  localparam int CW    = $clog2(BUF_DEPTH + 1);
  localparam logic [PCW-1:0] LAST_IDX = PCW'(PIX_NUM - 1);
  localparam logic [PW-1:0]  PTR_MAX  = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [31:0]     base_r;
  logic [WCW-1:0]  words_issued_r;
  logic [PCW-1:0]  pix_cnt_r;
  logic [31:0]     mem_r [BUF_DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            inflight_r;
  logic            half_r;
  logic            busy_r;
  logic            line_sent_r;
  logic            overrun_r;

  logic            start_s;
  logic            rd_s;
  logic            valid_s;
  logic            hs_s;
  logic            pop_s;
  logic            last_s;
  logic            last_hs_s;
  logic [15:0]     pix_raw_s;

  // Circular buffer pointer advance that also handles non power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_MAX) begin
      return PW'(0);
    end else begin
      return p + PW'(1);
    end
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: a line runs until its final pixel handshakes.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (line_done_in) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_hs_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output/control decode: read issue, handshake and unpack selection.
  always_comb begin
    start_s   = (state_r == ST_IDLE) && line_done_in;
    valid_s   = (count_r != CW'(0));
    hs_s      = valid_s && pix_ready_in;
    pop_s     = hs_s && half_r;
    last_s    = valid_s && (pix_cnt_r == LAST_IDX);
    last_hs_s = hs_s && (pix_cnt_r == LAST_IDX);
    // Reads in flight are counted against the buffer so a stalled consumer
    // can never cause an overflow.
    rd_s      = (state_r == ST_RUN) &&
                (32'(words_issued_r) < 32'(WORDS)) &&
                ((32'(count_r) + 32'(inflight_r)) < 32'(BUF_DEPTH));
    if (half_r) begin
      pix_raw_s = mem_r[rd_ptr_r][15:0];
    end else begin
      pix_raw_s = mem_r[rd_ptr_r][31:16];
    end
  end

  // Word buffer: capture returning read data, pop on lower-half handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
      wr_ptr_r   <= PW'(0);
      rd_ptr_r   <= PW'(0);
      count_r    <= CW'(0);
      inflight_r <= 1'b0;
      half_r     <= 1'b0;
    end else if (start_s) begin
      wr_ptr_r   <= PW'(0);
      rd_ptr_r   <= PW'(0);
      count_r    <= CW'(0);
      inflight_r <= 1'b0;
      half_r     <= 1'b0;
    end else begin
      inflight_r <= rd_s;
      if (inflight_r) begin
        mem_r[wr_ptr_r] <= ram_data_in;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (hs_s) begin
        half_r <= ~half_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({inflight_r, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Line bookkeeping: base latch, word-issue and pixel counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r         <= 32'd0;
      words_issued_r <= WCW'(0);
      pix_cnt_r      <= PCW'(0);
    end else if (start_s) begin
      base_r         <= base_addr_in;
      words_issued_r <= WCW'(0);
      pix_cnt_r      <= PCW'(0);
    end else begin
      if (rd_s) begin
        words_issued_r <= words_issued_r + WCW'(1);
      end
      if (hs_s) begin
        pix_cnt_r <= pix_cnt_r + PCW'(1);
      end
    end
  end

  // Registered status flags; overrun is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      line_sent_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      busy_r      <= (state_nx_s == ST_RUN);
      line_sent_r <= (state_nx_s == ST_DONE);
      if (line_done_in && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // Address wraps naturally modulo 2^32.
  assign ram_addr_o  = base_r + 32'({words_issued_r, 2'b00});
  assign ram_rd_o    = rd_s;
  assign pix_valid_o = valid_s;
  assign pix_last_o  = last_s;
  assign busy_o      = busy_r;
  assign line_sent_o = line_sent_r;
  assign overrun_o   = overrun_r;

`ifdef ADC_READER_BYTE_SWAP_EN
  assign pix_data_o = {pix_raw_s[7:0], pix_raw_s[15:8]};
`else
  assign pix_data_o = pix_raw_s;
`endif

endmodule

// File: tb/tb_adc_line_reader.sv
// Scoreboard bench for adc_line_reader: expected reads and pixels are derived
// from a RAM content model and pushed at start; a monitor compares them.
module tb_adc_line_reader;

  localparam int PIX_NUM   = 8;
  localparam int BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_done_in = 1'b0;
  logic [31:0] base_addr_in = 32'd0;
  logic [31:0] ram_addr_o;
  logic        ram_rd_o;
  logic [31:0] ram_data_in = 32'd0;
  logic [15:0] pix_data_o;
  logic        pix_valid_o;
  logic        pix_ready_in = 1'b1;
  logic        pix_last_o;
  logic        busy_o;
  logic        line_sent_o;
  logic        overrun_o;

  adc_line_reader #(.PIX_NUM(PIX_NUM), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .line_done_in(line_done_in), .base_addr_in(base_addr_in),
    .ram_addr_o(ram_addr_o), .ram_rd_o(ram_rd_o), .ram_data_in(ram_data_in),
    .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o), .pix_ready_in(pix_ready_in),
    .pix_last_o(pix_last_o), .busy_o(busy_o), .line_sent_o(line_sent_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model / scoreboard state
  logic [31:0] cur_base = 32'd0;
  logic [31:0] ram_seed = 32'd0;
  int          pat_mode = 0;
  int          rmode = 0;
  int          ph = 0;
  logic [3:0]  rpat = 4'b1001;
  logic [16:0] exp_pix[$];
  logic [31:0] exp_addr[$];
  int          reads_out = 0;
  int          mon_idx = 0;
  int          sent_cnt = 0;
  int          start_cyc = 0;
  int          first_valid_cyc = 0;
  int          last_hs_cyc = -100;
  bit          lat_armed = 1'b0;
  bit          tput_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %h, nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // RAM contents as seen by the reader
  function automatic logic [31:0] ram_word(input logic [31:0] addr);
    logic [31:0] k;
    case (pat_mode)
      0: begin
        k = (addr - cur_base) >> 2;
        return {16'hA000 + 16'(2 * k), 16'hA001 + 16'(2 * k)};
      end
      1: return (addr * 32'h9E3779B1) ^ ram_seed;
      default: return 32'h12345678;
    endcase
  endfunction

  function automatic logic [15:0] pix_of(input logic [31:0] w, input bit lo);
    logic [15:0] p;
    p = lo ? w[15:0] : w[31:16];
`ifdef ADC_READER_BYTE_SWAP_EN
    p = {p[7:0], p[15:8]};
`endif
    return p;
  endfunction

  // RAM with one-cycle read latency; junk when not reading
  always @(posedge clk) ram_data_in <= ram_rd_o ? ram_word(ram_addr_o) : $urandom();

  // ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: pix_ready_in = 1'b1;
        1: begin pix_ready_in = rpat[ph % 4]; ph++; end
        2: pix_ready_in = 1'($urandom_range(0, 1));
        default: pix_ready_in = 1'b1;
      endcase
    end
  end

  // monitor
  initial begin
    logic [16:0] e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ram_rd_o) begin
          if (exp_addr.size() == 0) begin
            fail_now("unexpected_read", ram_addr_o);
          end else begin
            a = exp_addr.pop_front();
            chk("ram_addr", ram_addr_o, a);
          end
          reads_out++;
          chk("outstanding_le_depth", 32'(reads_out <= BUF_DEPTH), 32'd1);
        end
        if (pix_valid_o) begin
          if (lat_armed) begin
            chk("first_pixel_latency", 32'(cyc - start_cyc), 32'd3);
            lat_armed = 1'b0;
            first_valid_cyc = cyc;
          end
          if (exp_pix.size() == 0) begin
            fail_now("unexpected_pixel", {16'd0, pix_data_o});
          end else begin
            e = exp_pix[0];
            chk("pix_data", {16'd0, pix_data_o}, {16'd0, e[15:0]});
            chk("pix_last", {31'd0, pix_last_o}, {31'd0, e[16]});
            if (pix_ready_in) begin
              void'(exp_pix.pop_front());
              mon_idx++;
              if (mon_idx % 2 == 0) reads_out--;
              if (e[16]) begin
                last_hs_cyc = cyc;
                if (tput_chk) chk("throughput_span", 32'(cyc - first_valid_cyc), 32'(PIX_NUM - 1));
                mon_idx = 0;
              end
            end
          end
        end else begin
          chk("last_without_valid", {31'd0, pix_last_o}, 32'd0);
        end
        if (line_sent_o) begin
          sent_cnt++;
          chk("line_sent_timing", 32'(cyc), 32'(last_hs_cyc + 1));
          chk("busy_in_done", {31'd0, busy_o}, 32'd0);
        end
      end
    end
  end

  task automatic start_line(input logic [31:0] base);
    logic [31:0] w;
    @(posedge clk);
    #1;
    base_addr_in = base;
    line_done_in = 1'b1;
    cur_base = base;
    for (int i = 0; i < PIX_NUM; i++) begin
      w = ram_word(base + 32'(4 * (i / 2)));
      exp_pix.push_back({(i == PIX_NUM - 1), pix_of(w, (i % 2) == 1)});
    end
    for (int k = 0; k < PIX_NUM / 2; k++) exp_addr.push_back(base + 32'(4 * k));
    start_cyc = cyc;
    lat_armed = 1'b1;
    tput_chk = (rmode == 0);
    ph = 0;
    @(posedge clk);
    #1;
    line_done_in = 1'b0;
    base_addr_in = $urandom();
    chk("busy_after_start", {31'd0, busy_o}, 32'd1);
  endtask

  task automatic pulse_only(input logic [31:0] base);
    @(posedge clk);
    #1;
    base_addr_in = base;
    line_done_in = 1'b1;
    @(posedge clk);
    #1;
    line_done_in = 1'b0;
  endtask

  task automatic wait_sent(input int target);
    int i;
    for (i = 0; i < 400 && sent_cnt < target; i++) @(posedge clk);
    chk("line_completed", 32'(sent_cnt >= target), 32'd1);
    chk("pix_queue_drained", 32'(exp_pix.size()), 32'd0);
    chk("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ram_addr"}, ram_addr_o, 32'd0);
    chk({tag, "_ram_rd"}, {31'd0, ram_rd_o}, 32'd0);
    chk({tag, "_pix_data"}, {16'd0, pix_data_o}, 32'd0);
    chk({tag, "_pix_valid"}, {31'd0, pix_valid_o}, 32'd0);
    chk({tag, "_pix_last"}, {31'd0, pix_last_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_line_sent"}, {31'd0, line_sent_o}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun_o}, 32'd0);
  endtask

  task automatic flush_model();
    exp_pix.delete();
    exp_addr.delete();
    reads_out = 0;
    mon_idx = 0;
    lat_armed = 1'b0;
  endtask

  initial begin
    int i;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed line, ready held high
    rmode = 0; pat_mode = 0;
    start_line(32'h0000_0100);
    wait_sent(1);

    // same line, ready 1,0,0,1 repeating
    rmode = 1;
    start_line(32'h0000_0100);
    wait_sent(2);

    // address wrap
    rmode = 0;
    start_line(32'hFFFF_FFF8);
    wait_sent(3);
    chk("overrun_clear_before", {31'd0, overrun_o}, 32'd0);

    // second start while busy
    start_line(32'h0000_0200);
    repeat (3) @(posedge clk);
    pulse_only(32'hDEAD_0000);
    wait_sent(4);
    repeat (20) @(posedge clk);
    chk("single_line_after_overrun", 32'(sent_cnt), 32'd4);
    chk("overrun_set", {31'd0, overrun_o}, 32'd1);

    // reset in the middle of a line
    start_line(32'h0000_0300);
    for (i = 0; i < 100 && mon_idx < 3; i++) @(negedge clk);
    chk("three_pixels_before_reset", 32'(mon_idx), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    flush_model();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_line(32'h0000_0400);
    wait_sent(5);

    // constant word 0x12345678
    pat_mode = 2;
    start_line(32'h0000_0500);
    wait_sent(6);

    // randomized lines
    pat_mode = 1;
    for (int n = 0; n < 6; n++) begin
      rmode = n % 3;
      ram_seed = $urandom();
      start_line($urandom() & 32'hFFFF_FFFC);
      wait_sent(7 + n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
